div_arb_ctrl: RTL and testbench

//  Sequencer and arbiter for the shared radix-2 SRT divider core. Accepts divide

---
 rtl/div_arb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_div_arb_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arb_ctrl.sv
// Round-robin arbiter and sequencer in front of a shared radix-2 SRT divider core.
// Optional one-entry result cache enabled by defining DIV_ARB_CTRL_RESULT_CACHE_EN.
module div_arb_ctrl #(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,
  parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_signed,
  input  logic [NREQ*32-1:0]    req_op1,
  input  logic [NREQ*32-1:0]    req_op2,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [31:0]           resp_quo,
  output logic [31:0]           resp_rem,
  input  logic                  flush,
  output logic                  busy,
  output logic                  div_enable,
  output logic                  div_sign_en,
  output logic [31:0]           div_op1,
  output logic [31:0]           div_op2,
  input  logic                  div_ready,
  input  logic [31:0]           div_quo,
  input  logic [31:0]           div_rem,
  input  logic                  div_complete
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q, id_q;
  logic [TAG_W-1:0]  tag_q;
  logic              signed_q, discard_q;
  logic [31:0]       op1_q, op2_q, quo_q, rem_q;

  logic [ID_W-1:0]   gnt_lo_d, gnt_hi_d, gnt_id_d, ptr_d;
  logic              any_valid_d, hi_found_d, accept_d, special_d;
  logic              sel_signed_d;
  logic [31:0]       sel_op1_d, sel_op2_d;
  logic [TAG_W-1:0]  sel_tag_d;
  logic              cache_hit_d;
  logic [31:0]       hit_quo_d, hit_rem_d;
  logic              core_keep_d;

  // Lowest valid index at/after the pointer wins, else lowest valid overall.
  always_comb begin
    gnt_lo_d    = '0;
    gnt_hi_d    = '0;
    any_valid_d = 1'b0;
    hi_found_d  = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid_d = 1'b1;
        gnt_lo_d    = ID_W'(i);
      end
      if (req_valid[i] && (ID_W'(i) >= ptr_q)) begin
        hi_found_d = 1'b1;
        gnt_hi_d   = ID_W'(i);
      end
    end
    gnt_id_d = hi_found_d ? gnt_hi_d : gnt_lo_d;
  end

  assign accept_d     = (state_q == IDLE) && !flush && div_ready && any_valid_d;
  assign ptr_d        = (gnt_id_d == ID_W'(NREQ - 1)) ? '0 : gnt_id_d + 1'b1;
  assign sel_signed_d = req_signed[gnt_id_d];
  assign sel_op1_d    = req_op1[32*gnt_id_d +: 32];
  assign sel_op2_d    = req_op2[32*gnt_id_d +: 32];
  assign sel_tag_d    = req_tag[TAG_W*gnt_id_d +: TAG_W];
  assign special_d    = (sel_op2_d == 32'h0) ||
                        (sel_signed_d && (sel_op1_d == 32'h8000_0000) && (sel_op2_d == 32'hFFFF_FFFF));
  assign core_keep_d  = (state_q == BUSY) && div_complete && !discard_q && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept_d && (gnt_id_d == ID_W'(gi));
    end
  endgenerate

`ifdef DIV_ARB_CTRL_RESULT_CACHE_EN
  logic        cache_vld_q, cache_sgn_q;
  logic [31:0] cache_op1_q, cache_op2_q, cache_quo_q, cache_rem_q;

  assign cache_hit_d = cache_vld_q && (cache_sgn_q == sel_signed_d) &&
                       (cache_op1_q == sel_op1_d) && (cache_op2_q == sel_op2_d);
  assign hit_quo_d   = cache_quo_q;
  assign hit_rem_d   = cache_rem_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_op1_q <= '0;
      cache_op2_q <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
    end else if (core_keep_d) begin
      cache_vld_q <= 1'b1;
      cache_sgn_q <= signed_q;
      cache_op1_q <= op1_q;
      cache_op2_q <= op2_q;
      cache_quo_q <= div_quo;
      cache_rem_q <= div_rem;
    end
  end
`else
  assign cache_hit_d = 1'b0;
  assign hit_quo_d   = '0;
  assign hit_rem_d   = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      tag_q     <= '0;
      signed_q  <= 1'b0;
      discard_q <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept_d) begin
          ptr_q    <= ptr_d;
          id_q     <= gnt_id_d;
          tag_q    <= sel_tag_d;
          signed_q <= sel_signed_d;
          op1_q    <= sel_op1_d;
          op2_q    <= sel_op2_d;
          if (sel_op2_d == 32'h0) begin
            quo_q   <= 32'hFFFF_FFFF;
            rem_q   <= sel_op1_d;
            state_q <= RESP;
          end else if (special_d) begin
            quo_q   <= 32'h8000_0000;
            rem_q   <= 32'h0;
            state_q <= RESP;
          end else if (cache_hit_d) begin
            quo_q   <= hit_quo_d;
            rem_q   <= hit_rem_d;
            state_q <= RESP;
          end else begin
            state_q <= LAUNCH;
          end
        end
        // The core cannot be aborted, so a flush here only marks the result for discard.
        LAUNCH: begin
          if (flush) discard_q <= 1'b1;
          state_q <= BUSY;
        end
        BUSY: begin
          if (div_complete) begin
            discard_q <= 1'b0;
            if (core_keep_d) begin
              quo_q   <= div_quo;
              rem_q   <= div_rem;
              state_q <= RESP;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        RESP: if (resp_ready || flush) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign div_enable  = (state_q == LAUNCH);
  assign resp_valid  = (state_q == RESP);
  assign div_sign_en = signed_q;
  assign div_op1     = op1_q;
  assign div_op2     = op2_q;
  assign resp_id     = id_q;
  assign resp_tag    = tag_q;
  assign resp_quo    = quo_q;
  assign resp_rem    = rem_q;

endmodule

// File: tb/tb_div_arb_ctrl.sv
// Scoreboard bench for div_arb_ctrl with a behavioural multi-cycle divider core.
module tb_div_arb_ctrl;
  localparam int NREQ  = 2;
  localparam int TAG_W = 4;
  localparam int ID_W  = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NREQ-1:0]       req_valid = '0, req_ready, req_signed = '0;
  logic [NREQ*32-1:0]    req_op1 = '0, req_op2 = '0;
  logic [NREQ*TAG_W-1:0] req_tag = '0;
  logic                  resp_valid, resp_ready = 1'b1;
  logic [ID_W-1:0]       resp_id;
  logic [TAG_W-1:0]      resp_tag;
  logic [31:0]           resp_quo, resp_rem;
  logic                  flush = 1'b0, busy, div_enable, div_sign_en;
  logic [31:0]           div_op1, div_op2;
  logic                  div_ready;
  logic [31:0]           div_quo, div_rem;
  logic                  div_complete;

  always #5 clk = ~clk;

  div_arb_ctrl #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_op1(req_op1), .req_op2(req_op2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_quo(resp_quo), .resp_rem(resp_rem),
    .flush(flush), .busy(busy), .div_enable(div_enable), .div_sign_en(div_sign_en),
    .div_op1(div_op1), .div_op2(div_op2), .div_ready(div_ready),
    .div_quo(div_quo), .div_rem(div_rem), .div_complete(div_complete)
  );

  // Divider core model: fixed latency, busy while computing, one-cycle complete strobe.
  logic       core_busy;
  logic [2:0] core_cnt;
  logic       core_sgn;
  logic [31:0] core_a, core_b;
  int         en_count;
  assign div_ready = !core_busy;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      core_busy <= 1'b0; core_cnt <= '0; div_complete <= 1'b0;
      div_quo <= '0; div_rem <= '0; core_sgn <= 1'b0; core_a <= '0; core_b <= '0;
      en_count <= 0;
    end else begin
      div_complete <= 1'b0;
      if (div_enable) en_count <= en_count + 1;
      if (div_enable && !core_busy) begin
        core_busy <= 1'b1; core_cnt <= 3'd3;
        core_sgn <= div_sign_en; core_a <= div_op1; core_b <= div_op2;
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy <= 1'b0;
          div_complete <= 1'b1;
          if (core_sgn) begin
            div_quo <= $signed(core_a) / $signed(core_b);
            div_rem <= $signed(core_a) % $signed(core_b);
          end else begin
            div_quo <= core_a / core_b;
            div_rem <= core_a % core_b;
          end
        end else begin
          core_cnt <= core_cnt - 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] tag;
    logic [31:0] quo;
    logic [31:0] rem;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
    else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = 32'h8000_0000; r = 0; end
    else if (sgn) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return {q, r};
  endfunction

  // Response monitor: a handshake (or flushed response) is committed at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && resp_valid && (resp_ready || flush)) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        if (resp_ready) begin
          check_eq("resp_id",  64'(resp_id),  64'(e.id));
          check_eq("resp_tag", 64'(resp_tag), 64'(e.tag));
          check_eq("resp_quo", 64'(resp_quo), 64'(e.quo));
          check_eq("resp_rem", 64'(resp_rem), 64'(e.rem));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input bit push, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    bit   got;
    req_signed[id] = sgn;
    req_op1[32*id +: 32] = a;
    req_op2[32*id +: 32] = b;
    req_tag[TAG_W*id +: TAG_W] = tag;
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) check_eq("accept_timeout", 64'd0, 64'd1);
    if (got && push) begin
      e.id = 32'(id); e.tag = 32'(tag); e.quo = eq; e.rem = er;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (!busy && !resp_valid) done = 1'b1;
      else tick();
    end
    if (!done) check_eq("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_complete();
    bit done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      if (div_complete) done = 1'b1;
      else tick();
    end
    if (!done) check_eq("complete_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int en0;
    int grants[4];
    int ng;
    logic [63:0] r;

    #1;
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_busy",       64'(busy),       64'd0);
    check_eq("rst_div_enable", 64'(div_enable), 64'd0);
    check_eq("rst_resp_quo",   64'(resp_quo),   64'd0);
    check_eq("rst_div_op1",    64'(div_op1),    64'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // T1: unsigned 100/7 through the core with latency checks
    en0 = en_count;
    issue(0, 1'b0, 32'd100, 32'd7, 4'h5, 1'b1, 32'd14, 32'd2);
    check_eq("t1_enable_c1", 64'(div_enable), 64'd1);
    tick();
    check_eq("t1_enable_c2", 64'(div_enable), 64'd0);
    check_eq("t1_busy",      64'(busy),       64'd1);
    wait_complete();
    check_eq("t1_no_resp_at_complete", 64'(resp_valid), 64'd0);
    tick();
    check_eq("t1_resp_after_complete", 64'(resp_valid), 64'd1);
    wait_idle();
    check_eq("t1_enable_pulses", 64'(en_count - en0), 64'd1);

    // T2: signed -7/2 on requester 1
    issue(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'h9, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    wait_idle();

    // T3: special cases resolved without the core
    en0 = en_count;
    issue(0, 1'b0, 32'h1234, 32'd0, 4'h3, 1'b1, 32'hFFFF_FFFF, 32'h1234);
    check_eq("t3_div0_resp_c1", 64'(resp_valid), 64'd1);
    check_eq("t3_div0_no_en",   64'(div_enable), 64'd0);
    wait_idle();
    issue(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hA, 1'b1, 32'h8000_0000, 32'd0);
    check_eq("t3_ovf_resp_c1", 64'(resp_valid), 64'd1);
    wait_idle();
    check_eq("t3_no_core_use", 64'(en_count - en0), 64'd0);

    // T4: both requesters valid continuously, expect alternating grants
    req_signed = '0;
    req_op1 = {32'd1000, 32'd50};
    req_op2 = {32'd9, 32'd3};
    req_tag = {4'h2, 4'h1};
    req_valid = 2'b11;
    ng = 0;
    for (int n = 0; n < 200 && ng < 4; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          r = ref_div(1'b0, req_op1[32*i +: 32], req_op2[32*i +: 32]);
          e.id = 32'(i); e.tag = 32'(req_tag[TAG_W*i +: TAG_W]);
          e.quo = r[63:32]; e.rem = r[31:0];
          sb_q.push_back(e);
          grants[ng] = i;
          ng++;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check_eq("t4_grant_count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) check_eq($sformatf("t4_grant%0d", k), 64'(grants[k]), 64'(k % 2));
    wait_idle();

    // T4b: response stall holds fields and blocks new accepts
    resp_ready = 1'b0;
    issue(0, 1'b0, 32'd77, 32'd5, 4'h6, 1'b1, 32'd15, 32'd2);
    req_op1[63:32] = 32'd8; req_op2[63:32] = 32'd2; req_tag[7:4] = 4'h7;
    req_valid[1] = 1'b1;
    for (int n = 0; n < 30 && !resp_valid; n++) tick();
    for (int n = 0; n < 5; n++) begin
      check_eq("t4_stall_valid", 64'(resp_valid), 64'd1);
      check_eq("t4_stall_quo",   64'(resp_quo),   64'd15);
      check_eq("t4_stall_rem",   64'(resp_rem),   64'd2);
      check_eq("t4_stall_ready", 64'(req_ready),  64'd0);
      tick();
    end
    req_valid[1] = 1'b0;
    resp_ready = 1'b1;
    wait_idle();

    // T5: flush in BUSY discards the result; controller stays busy until the core finishes
    issue(0, 1'b0, 32'd1000, 32'd10, 4'hC, 1'b0, 32'd0, 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int n = 0; n < 30 && !div_complete; n++) begin
      check_eq("t5_busy_hold", 64'(busy),       64'd1);
      check_eq("t5_no_resp",   64'(resp_valid), 64'd0);
      tick();
    end
    check_eq("t5_core_done", 64'(div_complete), 64'd1);
    tick();
    check_eq("t5_idle_after", 64'(busy),       64'd0);
    check_eq("t5_no_resp2",   64'(resp_valid), 64'd0);
    r = ref_div(1'b0, 32'd81, 32'd9);
    issue(1, 1'b0, 32'd81, 32'd9, 4'hD, 1'b1, r[63:32], r[31:0]);
    wait_idle();

    // T6: repeated operands; with the cache only the first uses the core
    en0 = en_count;
    issue(0, 1'b0, 32'd100, 32'd7, 4'h4, 1'b1, 32'd14, 32'd2);
    wait_idle();
    issue(1, 1'b0, 32'd100, 32'd7, 4'hE, 1'b1, 32'd14, 32'd2);
`ifdef DIV_ARB_CTRL_RESULT_CACHE_EN
    check_eq("t6_cache_resp_c1", 64'(resp_valid), 64'd1);
    wait_idle();
    check_eq("t6_enable_pulses", 64'(en_count - en0), 64'd1);
`else
    check_eq("t6_launch_c1", 64'(div_enable), 64'd1);
    wait_idle();
    check_eq("t6_enable_pulses", 64'(en_count - en0), 64'd2);
`endif

    for (int n = 0; n < 20 && sb_q.size() != 0; n++) tick();
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
